// File: rtl/jtag_tap_slave.sv
// jtag_tap_slave: IEEE 1149.1-style TAP responder oversampling tck/tms/tdi on clk.
// Ports: clk, rst_n (sync, active-low); tck/tms/tdi in, tdo out (JTAG pins);
//   tap_state (TAP state code), ir_value (latched instruction);
//   dr_capture_data in (user DR capture), dr_data/dr_update out (user DR update).
// Build option: define JTAG_TAP_IDCODE_EN to include the IDCODE register.
module jtag_tap_slave #(
  parameter int unsigned         IR_WIDTH      = 4,
  parameter int unsigned         DR_WIDTH      = 32,
  parameter logic [31:0]         IDCODE_VALUE  = 32'h149511C3,
  parameter logic [IR_WIDTH-1:0] USER_OPCODE   = 4'b1000,
  parameter logic [IR_WIDTH-1:0] IDCODE_OPCODE = 4'b0001
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_value,
  input  logic [DR_WIDTH-1:0] dr_capture_data,
  output logic [DR_WIDTH-1:0] dr_data,
  output logic                dr_update
);

  typedef enum logic [3:0] {
    ST_TLR      = 4'd0,
    ST_RTI      = 4'd1,
    ST_SEL_DR   = 4'd2,
    ST_CAP_DR   = 4'd3,
    ST_SH_DR    = 4'd4,
    ST_EX1_DR   = 4'd5,
    ST_PAUSE_DR = 4'd6,
    ST_EX2_DR   = 4'd7,
    ST_UPD_DR   = 4'd8,
    ST_SEL_IR   = 4'd9,
    ST_CAP_IR   = 4'd10,
    ST_SH_IR    = 4'd11,
    ST_EX1_IR   = 4'd12,
    ST_PAUSE_IR = 4'd13,
    ST_EX2_IR   = 4'd14,
    ST_UPD_IR   = 4'd15
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE =
    {{(IR_WIDTH-1){1'b0}}, 1'b1};

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = IDCODE_OPCODE;
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = '1;
`endif

  // Pin conditioning
  logic [2:0] tck_sync_q, tck_sync_d;
  logic [1:0] tms_sync_q, tms_sync_d;
  logic [1:0] tdi_sync_q, tdi_sync_d;
  logic       tck_rise;
  logic       tck_fall;
  logic       tms_s;
  logic       tdi_s;

  tap_state_e state_q, state_d;

  logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
  logic [IR_WIDTH-1:0] ir_value_q, ir_value_d;
  logic                bypass_q, bypass_d;
  logic [DR_WIDTH-1:0] user_sr_q, user_sr_d;
  logic [DR_WIDTH-1:0] dr_data_q, dr_data_d;
  logic                dr_update_q, dr_update_d;
  logic                tdo_q, tdo_d;

  logic sel_user;
  logic sel_idcode;
  logic dr_lsb;

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] idcode_sr_q, idcode_sr_d;
`else
  logic unused_idcode;
  assign unused_idcode = ^{IDCODE_VALUE, IDCODE_OPCODE};
`endif

  assign tck_sync_d = {tck_sync_q[1:0], tck};
  assign tms_sync_d = {tms_sync_q[0], tms};
  assign tdi_sync_d = {tdi_sync_q[0], tdi};

  assign tck_rise = tck_sync_q[1] & ~tck_sync_q[2];
  assign tck_fall = ~tck_sync_q[1] & tck_sync_q[2];
  assign tms_s    = tms_sync_q[1];
  assign tdi_s    = tdi_sync_q[1];

  // USER wins if both opcodes were ever configured equal.
  assign sel_user = (ir_value_q == USER_OPCODE);
`ifdef JTAG_TAP_IDCODE_EN
  assign sel_idcode = ~sel_user & (ir_value_q == IDCODE_OPCODE);
  assign dr_lsb = sel_user   ? user_sr_q[0]   :
                  sel_idcode ? idcode_sr_q[0] :
                               bypass_q;
`else
  assign sel_idcode = 1'b0;
  assign dr_lsb = sel_user ? user_sr_q[0] : bypass_q;
`endif

  // TAP controller next state
  always_comb begin
    state_d = state_q;
    if (tck_rise) begin
      unique case (state_q)
        ST_TLR:      state_d = tms_s ? ST_TLR    : ST_RTI;
        ST_RTI:      state_d = tms_s ? ST_SEL_DR : ST_RTI;
        ST_SEL_DR:   state_d = tms_s ? ST_SEL_IR : ST_CAP_DR;
        ST_CAP_DR:   state_d = tms_s ? ST_EX1_DR : ST_SH_DR;
        ST_SH_DR:    state_d = tms_s ? ST_EX1_DR : ST_SH_DR;
        ST_EX1_DR:   state_d = tms_s ? ST_UPD_DR : ST_PAUSE_DR;
        ST_PAUSE_DR: state_d = tms_s ? ST_EX2_DR : ST_PAUSE_DR;
        ST_EX2_DR:   state_d = tms_s ? ST_UPD_DR : ST_SH_DR;
        ST_UPD_DR:   state_d = tms_s ? ST_SEL_DR : ST_RTI;
        ST_SEL_IR:   state_d = tms_s ? ST_TLR    : ST_CAP_IR;
        ST_CAP_IR:   state_d = tms_s ? ST_EX1_IR : ST_SH_IR;
        ST_SH_IR:    state_d = tms_s ? ST_EX1_IR : ST_SH_IR;
        ST_EX1_IR:   state_d = tms_s ? ST_UPD_IR : ST_PAUSE_IR;
        ST_PAUSE_IR: state_d = tms_s ? ST_EX2_IR : ST_PAUSE_IR;
        ST_EX2_IR:   state_d = tms_s ? ST_UPD_IR : ST_SH_IR;
        ST_UPD_IR:   state_d = tms_s ? ST_SEL_DR : ST_RTI;
        default:     state_d = ST_TLR;
      endcase
    end
  end

  // Register actions: evaluated in the current state, then the
  // entry actions of the state being moved into.
  always_comb begin
    ir_sr_d     = ir_sr_q;
    ir_value_d  = ir_value_q;
    bypass_d    = bypass_q;
    user_sr_d   = user_sr_q;
    dr_data_d   = dr_data_q;
    dr_update_d = 1'b0;
    tdo_d       = tdo_q;
`ifdef JTAG_TAP_IDCODE_EN
    idcode_sr_d = idcode_sr_q;
`endif

    if (tck_rise) begin
      unique case (state_q)
        ST_CAP_IR: ir_sr_d = IR_CAPTURE;
        ST_SH_IR:  ir_sr_d = {tdi_s, ir_sr_q[IR_WIDTH-1:1]};
        ST_CAP_DR: begin
          if (sel_user) begin
            user_sr_d = dr_capture_data;
          end else if (sel_idcode) begin
`ifdef JTAG_TAP_IDCODE_EN
            idcode_sr_d = IDCODE_VALUE;
`endif
          end else begin
            bypass_d = 1'b0;
          end
        end
        ST_SH_DR: begin
          if (sel_user) begin
            user_sr_d = {tdi_s, user_sr_q[DR_WIDTH-1:1]};
          end else if (sel_idcode) begin
`ifdef JTAG_TAP_IDCODE_EN
            idcode_sr_d = {tdi_s, idcode_sr_q[31:1]};
`endif
          end else begin
            bypass_d = tdi_s;
          end
        end
        default: ;
      endcase

      // Update states are only entered from Exit states, which never
      // shift, so the _q shift values are the final scanned data.
      if (state_d == ST_UPD_IR) begin
        ir_value_d = ir_sr_q;
      end
      if (state_d == ST_TLR) begin
        ir_value_d = IR_RESET;
      end
      if (state_d == ST_UPD_DR && sel_user) begin
        dr_data_d   = user_sr_q;
        dr_update_d = 1'b1;
      end
    end

    if (tck_fall) begin
      if (state_q == ST_SH_IR) begin
        tdo_d = ir_sr_q[0];
      end else if (state_q == ST_SH_DR) begin
        tdo_d = dr_lsb;
      end else begin
        tdo_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tck_sync_q  <= '0;
      tms_sync_q  <= '0;
      tdi_sync_q  <= '0;
      state_q     <= ST_TLR;
      ir_sr_q     <= '0;
      ir_value_q  <= IR_RESET;
      bypass_q    <= 1'b0;
      user_sr_q   <= '0;
      dr_data_q   <= '0;
      dr_update_q <= 1'b0;
      tdo_q       <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_sr_q <= '0;
`endif
    end else begin
      tck_sync_q  <= tck_sync_d;
      tms_sync_q  <= tms_sync_d;
      tdi_sync_q  <= tdi_sync_d;
      state_q     <= state_d;
      ir_sr_q     <= ir_sr_d;
      ir_value_q  <= ir_value_d;
      bypass_q    <= bypass_d;
      user_sr_q   <= user_sr_d;
      dr_data_q   <= dr_data_d;
      dr_update_q <= dr_update_d;
      tdo_q       <= tdo_d;
`ifdef JTAG_TAP_IDCODE_EN
      idcode_sr_q <= idcode_sr_d;
`endif
    end
  end

  assign tdo       = tdo_q;
  assign tap_state = state_q;
  assign ir_value  = ir_value_q;
  assign dr_data   = dr_data_q;
  assign dr_update = dr_update_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// tb_jtag_tap_slave: randomized bench for jtag_tap_slave with a
// bit-level TAP reference model; follows JTAG_TAP_IDCODE_EN like the DUT.
`timescale 1ns/1ps
module tb_jtag_tap_slave;

  localparam logic [31:0] IDV     = 32'h149511C3;
  localparam logic [3:0]  USER_OP = 4'b1000;
  localparam logic [3:0]  ID_OP   = 4'b0001;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit          ID_EN  = 1'b1;
  localparam logic [3:0]  IR_RST = 4'b0001;
`else
  localparam bit          ID_EN  = 1'b0;
  localparam logic [3:0]  IR_RST = 4'b1111;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tck = 1'b0;
  logic        tms = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo;
  logic [3:0]  tap_state;
  logic [3:0]  ir_value;
  logic [31:0] dr_capture_data = '0;
  logic [31:0] dr_data;
  logic        dr_update;

  int n_tests = 0;
  int n_fail  = 0;
  int upd_seen = 0;
  int upd_dbl  = 0;
  logic upd_prev = 1'b0;

  // Reference model
  int          m_state;
  logic [3:0]  m_ir;
  logic [3:0]  m_ir_sr;
  logic [31:0] m_user_sr;
  logic [31:0] m_id_sr;
  logic [31:0] m_dr_data;
  logic        m_byp;
  int          m_upd;

  always #5 clk = ~clk;

  jtag_tap_slave dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .tck             (tck),
    .tms             (tms),
    .tdi             (tdi),
    .tdo             (tdo),
    .tap_state       (tap_state),
    .ir_value        (ir_value),
    .dr_capture_data (dr_capture_data),
    .dr_data         (dr_data),
    .dr_update       (dr_update)
  );

  always @(negedge clk) begin
    if (dr_update) begin
      upd_seen++;
      if (upd_prev) upd_dbl++;
    end
    upd_prev = dr_update;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int tap_next(input int s, input logic t);
    case (s)
      0:  return t ? 0  : 1;
      1:  return t ? 2  : 1;
      2:  return t ? 9  : 3;
      3:  return t ? 5  : 4;
      4:  return t ? 5  : 4;
      5:  return t ? 8  : 6;
      6:  return t ? 7  : 6;
      7:  return t ? 8  : 4;
      8:  return t ? 2  : 1;
      9:  return t ? 0  : 10;
      10: return t ? 12 : 11;
      11: return t ? 12 : 11;
      12: return t ? 15 : 13;
      13: return t ? 14 : 13;
      14: return t ? 15 : 11;
      default: return t ? 2 : 1;
    endcase
  endfunction

  function automatic bit m_sel_user();
    return m_ir == USER_OP;
  endfunction

  function automatic bit m_sel_id();
    return ID_EN && (m_ir == ID_OP) && (m_ir != USER_OP);
  endfunction

  task automatic model_reset();
    m_state   = 0;
    m_ir      = IR_RST;
    m_ir_sr   = '0;
    m_user_sr = '0;
    m_id_sr   = '0;
    m_dr_data = '0;
    m_byp     = 1'b0;
  endtask

  task automatic model_rise(input logic t_ms, input logic t_di);
    int ns;
    bit u;
    bit d;
    u = m_sel_user();
    d = m_sel_id();
    if (m_state == 10) m_ir_sr = 4'b0001;
    if (m_state == 11) m_ir_sr = (m_ir_sr >> 1) | (4'(t_di) << 3);
    if (m_state == 3) begin
      if (u) m_user_sr = dr_capture_data;
      else if (d) m_id_sr = IDV;
      else m_byp = 1'b0;
    end
    if (m_state == 4) begin
      if (u) m_user_sr = (m_user_sr >> 1) | (32'(t_di) << 31);
      else if (d) m_id_sr = (m_id_sr >> 1) | (32'(t_di) << 31);
      else m_byp = t_di;
    end
    ns = tap_next(m_state, t_ms);
    if (ns == 15) m_ir = m_ir_sr;
    if (ns == 0) m_ir = IR_RST;
    if (ns == 8 && u) begin
      m_dr_data = m_user_sr;
      m_upd++;
    end
    m_state = ns;
  endtask

  function automatic logic model_tdo();
    if (m_state == 11) return m_ir_sr[0];
    if (m_state == 4) begin
      if (m_sel_user()) return m_user_sr[0];
      if (m_sel_id()) return m_id_sr[0];
      return m_byp;
    end
    return 1'b0;
  endfunction

  task automatic step(input logic t_ms, input logic t_di, output logic t_do);
    tms = t_ms;
    tdi = t_di;
    repeat (4) @(negedge clk);
    tck = 1'b1;
    model_rise(t_ms, t_di);
    repeat (6) @(negedge clk);
    check("state", 64'(tap_state), 64'(m_state));
    tck = 1'b0;
    repeat (6) @(negedge clk);
    t_do = tdo;
    check("tdo", 64'(tdo), 64'(model_tdo()));
    check("ir_value", 64'(ir_value), 64'(m_ir));
    check("dr_data", 64'(dr_data), 64'(m_dr_data));
    check("upd_cnt", 64'(upd_seen), 64'(m_upd));
  endtask

  // Starts and ends in RTI.
  task automatic shift_ir(input logic [3:0] din, output logic [3:0] dout);
    logic b;
    dout = '0;
    step(1'b1, 1'b0, b);
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    dout[0] = b;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, din[i], b);
      if (i < 3) dout[i+1] = b;
    end
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
  endtask

  // Starts and ends in RTI.
  task automatic shift_dr(input int n, input logic [31:0] din,
                          output logic [31:0] dout);
    logic b;
    dout = '0;
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    dout[0] = b;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, din[i], b);
      if (i < n - 1) dout[i+1] = b;
    end
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
  endtask

  task automatic goto_rti();
    logic b;
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), b);
    step(1'b0, 1'b0, b);
  endtask

  initial begin
    logic        b;
    logic [3:0]  o4;
    logic [31:0] o32;
    logic [31:0] din;
    int          u0;

    model_reset();
    m_upd = 0;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 64'(tap_state), 64'(0));
    check("rst_ir", 64'(ir_value), 64'(IR_RST));
    check("rst_tdo", 64'(tdo), 64'(0));
    check("rst_dr_data", 64'(dr_data), 64'(0));
    check("rst_dr_update", 64'(dr_update), 64'(0));

    goto_rti();
    check("rti_state", 64'(tap_state), 64'(1));
    check("rti_ir", 64'(ir_value), 64'(IR_RST));
    check("rti_tdo", 64'(tdo), 64'(0));

    din = $urandom;
    shift_dr(32, din, o32);
    if (ID_EN) check("idcode", 64'(o32), 64'(IDV));
    else check("bypass_echo", 64'(o32), 64'({din[30:0], 1'b0}));

    shift_ir(4'b1111, o4);
    check("ir_cap_1111", 64'(o4), 64'(4'b0001));
    check("ir_1111", 64'(ir_value), 64'(4'b1111));
    shift_dr(4, 32'h0000_000D, o32);
    check("bypass_1011", 64'(o32[3:0]), 64'(4'b1010));

    shift_ir(4'b1010, o4);
    check("ir_cap_1010", 64'(o4), 64'(4'b0001));
    check("ir_1010", 64'(ir_value), 64'(4'b1010));

    // Reset in the middle of a user DR scan.
    shift_ir(USER_OP, o4);
    dr_capture_data = 32'hCAFE_F00D;
    u0 = upd_seen;
    step(1'b1, 1'b0, b);
    step(1'b0, 1'b0, b);
    step(1'b0, 1'b0, b);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, b);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (6) @(negedge clk);
    check("midrst_state", 64'(tap_state), 64'(0));
    check("midrst_ir", 64'(ir_value), 64'(IR_RST));
    check("midrst_tdo", 64'(tdo), 64'(0));
    check("midrst_dr_data", 64'(dr_data), 64'(0));
    check("midrst_no_upd", 64'(upd_seen - u0), 64'(0));

    step(1'b0, 1'b0, b);
    shift_ir(USER_OP, o4);
    dr_capture_data = 32'hDEADBEEF;
    u0 = upd_seen;
    shift_dr(32, 32'h12345678, o32);
    check("user_capture", 64'(o32), 64'(32'hDEADBEEF));
    check("user_dr_data", 64'(dr_data), 64'(32'h12345678));
    check("user_one_pulse", 64'(upd_seen - u0), 64'(1));

    for (int n = 0; n < 700; n++) begin
      dr_capture_data = $urandom;
      if ($urandom_range(0, 39) == 0) begin
        goto_rti();
        case ($urandom_range(0, 2))
          0:       shift_ir(USER_OP, o4);
          1:       shift_ir(ID_OP, o4);
          default: shift_ir(4'($urandom), o4);
        endcase
        check("rand_ir_cap", 64'(o4), 64'(4'b0001));
      end else begin
        step($urandom_range(0, 3) == 0, 1'($urandom), b);
      end
    end

    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom), b);
    check("final_tlr", 64'(tap_state), 64'(0));
    check("upd_no_double", 64'(upd_dbl), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
